// File: rtl/sram_table_loader.sv
// Packs a valid/ready byte stream little-endian into 32-bit words and writes them to SRAM port 0
// at consecutive (wrapping) addresses; LOADER_CHECKSUM_EN adds a mod-256 byte checksum output.
module sram_table_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  start_addr,
  input  logic [8:0]  word_count,
  input  logic        abort,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        csb0,
  output logic        web0,
  output logic [3:0]  wmask0,
  output logic [7:0]  addr0,
  output logic [31:0] din0,
  output logic        busy,
  output logic        done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]  r_state;
  logic [7:0]  r_addr;
  logic [8:0]  r_remaining;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_word;
  logic [7:0]  r_addr0;
  logic [31:0] r_din0;
  logic        w_accept;

  // abort wins over a byte offered in the same cycle
  assign w_accept = (r_state == S_COLLECT) && byte_valid && !abort;

  assign byte_ready = (r_state == S_COLLECT);
  assign csb0       = (r_state != S_WRITE);
  assign web0       = (r_state != S_WRITE);
  assign wmask0     = (r_state == S_WRITE) ? 4'hF : 4'h0;
  assign addr0      = r_addr0;
  assign din0       = r_din0;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= 8'h00;
      r_remaining <= 9'd0;
      r_byte_idx  <= 2'd0;
      r_word      <= 24'h0;
      r_addr0     <= 8'h00;
      r_din0      <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr      <= start_addr;
            r_remaining <= word_count;
            r_byte_idx  <= 2'd0;
            r_state     <= (word_count == 9'd0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (w_accept) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0:    r_word[7:0]   <= byte_data;
              2'd1:    r_word[15:8]  <= byte_data;
              2'd2:    r_word[23:16] <= byte_data;
              default: begin
                // lane 3 goes straight to the port register so the write needs no extra cycle
                r_din0  <= {byte_data, r_word};
                r_addr0 <= r_addr;
                r_state <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          r_addr      <= r_addr + 8'd1;
          r_remaining <= r_remaining - 9'd1;
          if (abort)
            r_state <= S_IDLE;
          else if (r_remaining == 9'd1)
            r_state <= S_DONE;
          else
            r_state <= S_COLLECT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_checksum <= 8'h00;
    else if (r_state == S_IDLE && start)
      r_checksum <= 8'h00;
    else if (w_accept)
      r_checksum <= r_checksum + byte_data;
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_sram_table_loader.sv
// Bench for sram_table_loader: vector table of loads plus abort, reset-during-write and checksum sequences.
module tb_sram_table_loader;

  logic        clk = 1'b0;
  logic        reset, start, abort, byte_valid;
  logic [7:0]  start_addr, byte_data;
  logic [8:0]  word_count;
  logic        byte_ready, csb0, web0, busy, done;
  logic [3:0]  wmask0;
  logic [7:0]  addr0;
  logic [31:0] din0;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  sram_table_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .abort      (abort),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .csb0       (csb0),
    .web0       (web0),
    .wmask0     (wmask0),
    .addr0      (addr0),
    .din0       (din0),
    .busy       (busy),
    .done       (done)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sa;
    int         wc;
    bit         stall;
    logic [7:0] base;
    int         exp_writes;
    int         exp_lat;
  } vec_t;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t       vecs[5];
  wr_t        exp_q[$];
  logic [7:0] buf_b[1024];
  int         hits[256];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         wr_count = 0;
  int         done_count = 0;
  int         done_cyc = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // scoreboard side: every SRAM write must match the next word the driver completed
  always @(negedge clk) begin
    if (!csb0 && !web0) begin
      wr_t e;
      wr_count++;
      hits[addr0]++;
      chk("wr_byte_ready_low", byte_ready, 0);
      chk("wr_wmask", wmask0, 4'hF);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h required none", addr0, din0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", addr0, e.a);
        chk("wr_data", din0, e.d);
      end
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic stream(input int nbytes, input bit stall, input logic [7:0] sa,
                        input int start_pulse_at, output int k);
    int          budget;
    logic [31:0] w;
    logic [7:0]  a;
    wr_t         e;
    k = 0; budget = 0; a = sa; w = 0;
    while (k < nbytes && budget < 5 * nbytes + 50) begin
      byte_valid = stall ? (budget % 2 == 1) : 1'b1;
      byte_data  = buf_b[k];
      start      = (k == start_pulse_at);
      if (byte_valid && byte_ready) begin
        w[8*(k%4) +: 8] = buf_b[k];
        if (k % 4 == 3) begin
          e.a = a; e.d = w;
          exp_q.push_back(e);
          a = a + 8'd1;
        end
        k++;
      end
      budget++;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] sa, input int wc, input bit stall, output int lat);
    int t0, k;
    wr_count = 0; done_count = 0; done_cyc = -1;
    foreach (hits[i]) hits[i] = 0;
    @(negedge clk);
    start = 1'b1; start_addr = sa; word_count = wc[8:0];
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    stream(4 * wc, stall, sa, -1, k);
    chk("bytes_accepted", k, 4 * wc);
    for (int i = 0; i < 20 && done_count == 0; i++) begin
      @(negedge clk); #1;
    end
    repeat (2) @(negedge clk);
    chk("busy_after_done", busy, 0);
    lat = done_cyc - t0;
  endtask

  initial begin
    int lat, k, bad;
    vecs[0] = '{8'h10, 2,   1'b0, 8'h01, 2,   10};
    vecs[1] = '{8'hFF, 2,   1'b1, 8'h11, 2,   -1};
    vecs[2] = '{8'h00, 0,   1'b0, 8'h00, 0,   0};
    vecs[3] = '{8'hF0, 32,  1'b0, 8'h40, 32,  160};
    vecs[4] = '{8'h00, 256, 1'b0, 8'h80, 256, 1280};

    reset = 1'b1; start = 1'b1; abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    start_addr = 8'h55; word_count = 9'd3;
    repeat (3) @(negedge clk);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_csb0", csb0, 1);
    chk("rst_web0", web0, 1);
    chk("rst_wmask0", wmask0, 0);
    chk("rst_addr0", addr0, 0);
    chk("rst_din0", din0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("rst_checksum", checksum, 0);
`endif
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", busy, 0);
    chk("no_write_in_reset", wr_count, 0);

    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < 1024; j++) buf_b[j] = vecs[v].base + j[7:0];
      run_load(vecs[v].sa, vecs[v].wc, vecs[v].stall, lat);
      chk($sformatf("v%0d_writes", v), wr_count, vecs[v].exp_writes);
      chk($sformatf("v%0d_done_pulses", v), done_count, 1);
      chk($sformatf("v%0d_queue_empty", v), exp_q.size(), 0);
      if (vecs[v].exp_lat >= 0)
        chk($sformatf("v%0d_start_to_done", v), lat, vecs[v].exp_lat);
      if (vecs[v].wc == 256) begin
        bad = 0;
        foreach (hits[i]) if (hits[i] != 1) bad++;
        chk("every_addr_once", bad, 0);
      end
    end

    // abort two bytes into word 3, with a stray start mid-load
    for (int j = 0; j < 1024; j++) buf_b[j] = 8'hA0 + j[7:0];
    wr_count = 0; done_count = 0;
    @(negedge clk);
    start = 1'b1; start_addr = 8'h40; word_count = 9'd4;
    @(negedge clk);
    start = 1'b0; word_count = 9'd1;
    stream(10, 1'b0, 8'h40, 5, k);
    chk("abort_bytes_before", k, 10);
    abort = 1'b1; byte_valid = 1'b1; byte_data = buf_b[10];
    @(negedge clk);
    abort = 1'b0; byte_valid = 1'b0;
    chk("abort_busy_low", busy, 0);
    chk("abort_byte_ready_low", byte_ready, 0);
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] s;
      s = 8'h00;
      for (int j = 0; j < 10; j++) s = s + buf_b[j];
      chk("abort_partial_checksum", checksum, s);
    end
`endif
    repeat (10) @(negedge clk);
    chk("abort_writes", wr_count, 2);
    chk("abort_no_done", done_count, 0);
    chk("abort_queue_empty", exp_q.size(), 0);

    // reset asserted during the write cycle
    wr_count = 0;
    @(negedge clk);
    start = 1'b1; start_addr = 8'h20; word_count = 9'd2;
    @(negedge clk);
    start = 1'b0;
    stream(4, 1'b0, 8'h20, -1, k);
    chk("midwr_in_write", csb0, 0);
    #2 reset = 1'b1;
    #1;
    chk("midwr_csb0_async", csb0, 1);
    chk("midwr_web0_async", web0, 1);
    chk("midwr_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0; byte_valid = 1'b1;
    repeat (8) @(negedge clk);
    byte_valid = 1'b0;
    chk("midwr_writes", wr_count, 1);
    chk("midwr_queue_empty", exp_q.size(), 0);

`ifdef LOADER_CHECKSUM_EN
    buf_b[0] = 8'hFF; buf_b[1] = 8'h02; buf_b[2] = 8'h00; buf_b[3] = 8'h00;
    run_load(8'h05, 1, 1'b0, lat);
    chk("checksum_wrap", checksum, 8'h01);
    chk("checksum_done", done_count, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_table_loader.md
# sram_table_loader

Write-side companion to the counter-addressed lookup table: accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, and writes them into port 0 (csb0/web0/wmask0/addr0/din0) of the 32x256 SRAM macro at consecutive addresses. The counter reads the same table through port 1. The block exists so that software or a host interface can reload the table without generating raw SRAM port-0 signals.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; also the SRAM clk0
- reset  in  1  asynchronous, active-high
- start  in  1  begin a load; sampled only in IDLE
- start_addr  in  8  first SRAM word address
- word_count  in  9  words to write, 0..256; 0 completes with no writes
- abort  in  1  cancel the load; a partial word is discarded
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- csb0  out  1  SRAM port-0 chip select, active-low
- web0  out  1  SRAM port-0 write enable, active-low
- wmask0  out  4  SRAM byte write mask
- addr0  out  8  SRAM word address
- din0  out  32  SRAM write data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- checksum  out  8  present only with LOADER_CHECKSUM_EN

## Operation
- All outputs are registered or decoded directly from registered state.
- Reset values: byte_ready=0, csb0=1, web0=1, wmask0=0, addr0=0, din0=0, busy=0, done=0, checksum=0. State is IDLE.
- States:
  - IDLE → COLLECT on start when word_count≠0. Latches addr←start_addr, remaining←word_count, byte_idx←0.
  - IDLE → DONE on start when word_count=0.
  - COLLECT: byte_ready=1. On byte_valid&&byte_ready, byte_data goes into word lane byte_idx (lane 0 = bits 7:0), and byte_idx increments. Accepting the byte with byte_idx=3 moves to WRITE.
  - WRITE, exactly one cycle: csb0=0, web0=0, wmask0=4'hF, addr0=addr, din0=word, byte_ready=0. On exit, addr←addr+1 (wraps 8'hFF→8'h00) and remaining←remaining−1. Moves to DONE if the new remaining is 0, otherwise to COLLECT.
  - DONE, one cycle: done=1, then → IDLE.
- Outside WRITE: csb0=1, web0=1, wmask0=0. addr0 and din0 hold their last values.
- abort in COLLECT or WRITE returns to IDLE next cycle. A write already presented in the WRITE cycle still completes at that edge. abort produces no done pulse.
- abort has priority over byte acceptance in the same cycle.
- start outside IDLE is ignored. abort in IDLE or DONE is ignored.
- Address wrap is silent. start_addr=8'hF0 with word_count=32 writes 0xF0..0xFF, then 0x00..0x0F.

## Timing
- Fourth byte accepted at edge N: WRITE is active for the cycle N→N+1, and the SRAM captures at edge N+1.
- COLLECT is re-entered at N+1, so byte_ready drops for exactly one cycle per word.
- Sustained throughput is 4 bytes per 5 cycles.
- Last word: done is high during cycle N+1→N+2, and busy falls at N+2.
- start at edge S: byte_ready=1 from S. done is high S→S+1 for word_count=0.
- Reset mid-WRITE: csb0 and web0 go high immediately (asynchronously), and no further writes occur.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - The checksum port exists.
  - It holds the mod-256 sum of all bytes accepted since the last start, cleared to 0 on start.
  - It is valid and stable from done until the next start.
  - abort leaves it holding the partial sum.
- LOADER_CHECKSUM_EN undefined: no checksum port or logic; behaviour is otherwise identical.

## Test plan
- Reset with start held high → all outputs at reset values, no SRAM write; after release, IDLE.
- start_addr=0x10, word_count=2, bytes 01..08 streamed continuously → writes 0x10←0x04030201 and 0x11←0x08070605, each with wmask0=F for one cycle; done pulses once; byte_ready low one cycle after each 4th byte.
- start_addr=0xFF, word_count=2, byte_valid toggling every other cycle → writes at 0xFF then 0x00; data is unaffected by stalls.
- word_count=0 → done one cycle after start, csb0 never low; word_count=256 → 256 writes covering every address exactly once.
- abort after 2 bytes of word 3 → no write for word 3, no done pulse, busy low next cycle; start during the load is ignored.
- LOADER_CHECKSUM_EN, bytes 0xFF,0x02,0x00,0x00 → checksum=0x01 at done.
